// File: rtl/mp_reg_file_pkg.sv
// Shared types and defaults for the MIPS register file and its busy scoreboard.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 32;

    typedef logic [4:0] reg_addr_t;

    localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/mp_reg_file_if.sv
// Bus bundle between decode/writeback and the register file: reads, writes, reserve and busy status.
interface mp_reg_file_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2,
    parameter int ADDR_W = $clog2(DEPTH)
);

    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*ADDR_W-1:0] wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic                     rsv_en;
    logic [ADDR_W-1:0]        rsv_addr;
    logic                     any_busy;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        input  rd_data, rd_busy, any_busy
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        output rd_data, rd_busy, any_busy
    );

endinterface

// File: rtl/mp_reg_file_scoreboard.sv
// Per-register busy flags: set by reserve at issue, cleared by writeback; reserve wins a same-cycle clash.
// REGFILE_BYPASS_EN forwards a same-cycle writeback clear (or reserve) onto rd_busy.
module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    input  logic [NUM_WR-1:0]        wr_en_i,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
    input  logic                     rsv_en_i,
    input  logic [ADDR_W-1:0]        rsv_addr_i,
    output logic [NUM_RD-1:0]        rd_busy_o,
    output logic                     any_busy_o
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [ADDR_W-1:0] rdAddr;

    // Reserve is applied after the writeback clears so a newer producer keeps the register busy.
    always_comb begin
        busy_d = busy_q;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en_i[j] && wr_addr_i[j*ADDR_W +: ADDR_W] != ZERO_ADDR)
                busy_d[wr_addr_i[j*ADDR_W +: ADDR_W]] = 1'b0;
        end
        if (rsv_en_i && rsv_addr_i != ZERO_ADDR)
            busy_d[rsv_addr_i] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            busy_q <= '0;
        else
            busy_q <= busy_d;
    end

    always_comb begin
        rd_busy_o = '0;
        rdAddr    = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rdAddr       = rd_addr_i[i*ADDR_W +: ADDR_W];
            rd_busy_o[i] = busy_q[rdAddr];
`ifdef REGFILE_BYPASS_EN
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en_i[j] && rdAddr != ZERO_ADDR && wr_addr_i[j*ADDR_W +: ADDR_W] == rdAddr)
                    rd_busy_o[i] = rsv_en_i && (rsv_addr_i == rdAddr);
            end
`endif
        end
    end

    assign any_busy_o = |busy_q;

endmodule

// File: rtl/mp_reg_file.sv
// Multi-port MIPS register file (r0 hardwired to zero) with a busy scoreboard for hazard detection.
// Optional macro REGFILE_BYPASS_EN enables same-cycle write-to-read forwarding.
module mp_reg_file
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input logic          clk,
    input logic          rst,
    mp_reg_file_if.slave bus
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0]        regs_q [DEPTH];
    logic [DATA_W-1:0]        regs_d [DEPTH];
    logic [NUM_RD*DATA_W-1:0] rdData;
    logic [ADDR_W-1:0]        rdAddr;

    // Higher-indexed write ports are visited last, so they win on an address collision.
    always_comb begin
        regs_d = regs_q;
        for (int j = 0; j < NUM_WR; j++) begin
            if (bus.wr_en[j] && bus.wr_addr[j*ADDR_W +: ADDR_W] != ZERO_ADDR)
                regs_d[bus.wr_addr[j*ADDR_W +: ADDR_W]] = bus.wr_data[j*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++)
                regs_q[k] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // r0 is never written, so reading it naturally yields zero.
    always_comb begin
        rdData = '0;
        rdAddr = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rdAddr                     = bus.rd_addr[i*ADDR_W +: ADDR_W];
            rdData[i*DATA_W +: DATA_W] = regs_q[rdAddr];
`ifdef REGFILE_BYPASS_EN
            for (int j = 0; j < NUM_WR; j++) begin
                if (bus.wr_en[j] && rdAddr != ZERO_ADDR && bus.wr_addr[j*ADDR_W +: ADDR_W] == rdAddr)
                    rdData[i*DATA_W +: DATA_W] = bus.wr_data[j*DATA_W +: DATA_W];
            end
`endif
        end
    end

    assign bus.rd_data = rdData;

    reg_scoreboard #(
        .DEPTH  (DEPTH),
        .NUM_RD (NUM_RD),
        .NUM_WR (NUM_WR),
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .rd_addr_i  (bus.rd_addr),
        .wr_en_i    (bus.wr_en),
        .wr_addr_i  (bus.wr_addr),
        .rsv_en_i   (bus.rsv_en),
        .rsv_addr_i (bus.rsv_addr),
        .rd_busy_o  (bus.rd_busy),
        .any_busy_o (bus.any_busy)
    );

endmodule
